// File: rtl/geo_pkg.sv
// Shared types and constants for the player vertical-motion blocks.
package geo_pkg;
  typedef enum logic [1:0] {GROUNDED, RISING, FALLING, RESPAWN} jump_state_t;
  typedef logic signed [7:0] vel_t;
  localparam int unsigned SCREEN_H  = 480;
  localparam logic [7:0]  KEY_SPACE = 8'h2C;
endpackage

// File: rtl/frame_tick_gen.sv
// Brings vsync into the Clk domain and emits a one-cycle pulse per frame.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);
  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect
  logic [2:0] sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], frame_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/player_jump_ctrl.sv
// Per-frame jump/gravity integrator for the player cube.
// Optional landing jump buffer enabled by defining JUMP_BUFFER_EN.
module player_jump_ctrl
  import geo_pkg::*;
#(
  parameter int         GROUND_Y       = 400,
  parameter int         CEIL_Y         = 16,
  parameter int         JUMP_V         = 12,
  parameter int         GRAVITY        = 1,
  parameter int         MAX_FALL       = 15,
  parameter int         RESPAWN_FRAMES = 30,
  parameter logic [7:0] KEY_JUMP       = 8'h1A
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        internal_reset,
  input  logic        screen,
  output logic [9:0]  player_y,
  output logic        on_ground,
  output logic        jumping,
  output logic [15:0] jump_count
);
  localparam logic signed [10:0] GND_S    = 11'(GROUND_Y);
  localparam logic signed [10:0] CEIL_S   = 11'(CEIL_Y);
  localparam logic [9:0]         GND_Y10  = 10'(GROUND_Y);
  localparam logic [9:0]         CEIL_Y10 = 10'(CEIL_Y);
  localparam logic [9:0]         LAUNCH_Y = 10'(GROUND_Y - JUMP_V);
  localparam vel_t               JUMP_VEL = vel_t'(-JUMP_V);
  localparam vel_t               GRAV_V   = vel_t'(GRAVITY);
  localparam vel_t               MAXF_V   = vel_t'(MAX_FALL);
  localparam logic [7:0]         RSP_CNT  = 8'(RESPAWN_FRAMES);
`ifdef JUMP_BUFFER_EN
  localparam logic signed [10:0] BUF_S    = 11'(GROUND_Y - 3*MAX_FALL);
  logic buf_q, buf_d;
`endif

  jump_state_t       state_q, state_d;
  logic [9:0]        y_q, y_d;
  vel_t              vel_q, vel_d, vel_up, vel_dn;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       jc_q, jc_d;
  logic signed [10:0] y_up, y_dn;
  logic              tick, key, launch;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign key = (keycode == KEY_JUMP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= GROUNDED;
      y_q     <= GND_Y10;
      vel_q   <= '0;
      cnt_q   <= '0;
      jc_q    <= '0;
`ifdef JUMP_BUFFER_EN
      buf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      cnt_q   <= cnt_d;
      jc_q    <= jc_d;
`ifdef JUMP_BUFFER_EN
      buf_q   <= buf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    jc_d    = jc_q;
    launch  = 1'b0;
`ifdef JUMP_BUFFER_EN
    buf_d   = buf_q;
`endif
    vel_up  = vel_q + GRAV_V;
    vel_dn  = (vel_up > MAXF_V) ? MAXF_V : vel_up;
    y_up    = {1'b0, y_q} + {{3{vel_up[7]}}, vel_up};
    y_dn    = {1'b0, y_q} + {{3{vel_dn[7]}}, vel_dn};

    if (internal_reset) begin
      state_d = RESPAWN;
      y_d     = GND_Y10;
      vel_d   = '0;
      cnt_d   = RSP_CNT;
`ifdef JUMP_BUFFER_EN
      buf_d   = 1'b0;
`endif
    end else if (!screen) begin
      state_d = GROUNDED;
      y_d     = GND_Y10;
      vel_d   = '0;
      cnt_d   = '0;
`ifdef JUMP_BUFFER_EN
      buf_d   = 1'b0;
`endif
    end else if (tick) begin
      case (state_q)
        GROUNDED: launch = key;
        RISING: begin
          vel_d = vel_up;
          y_d   = y_up[9:0];
          if (y_up < CEIL_S) begin
            y_d     = CEIL_Y10;
            vel_d   = '0;
            state_d = FALLING;
          end else if (!vel_up[7]) begin
            state_d = FALLING;
          end
        end
        FALLING: begin
          vel_d = vel_dn;
          y_d   = y_dn[9:0];
`ifdef JUMP_BUFFER_EN
          if (key && (y_dn >= BUF_S)) buf_d = 1'b1;
`endif
          if (y_dn >= GND_S) begin
            y_d     = GND_Y10;
            vel_d   = '0;
            state_d = GROUNDED;
`ifdef JUMP_BUFFER_EN
            launch  = buf_d;
`endif
          end
        end
        RESPAWN: begin
          y_d   = GND_Y10;
          vel_d = '0;
          // leave on the tick that drains the counter so the next tick can jump
          if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = GROUNDED;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      endcase

      if (launch) begin
        state_d = RISING;
        vel_d   = JUMP_VEL;
        y_d     = LAUNCH_Y;
        jc_d    = (jc_q == 16'hFFFF) ? jc_q : jc_q + 16'd1;
`ifdef JUMP_BUFFER_EN
        buf_d   = 1'b0;
`endif
      end
    end
  end

  assign player_y   = y_q;
  assign on_ground  = (state_q == GROUNDED) || (state_q == RESPAWN);
  assign jumping    = (state_q == RISING) || (state_q == FALLING);
  assign jump_count = jc_q;
endmodule

// File: tb/tb_player_jump_ctrl.sv
// Drives two player_jump_ctrl instances (default ceiling and a low ceiling) against a frame-level model.
module tb_player_jump_ctrl;
  localparam logic [7:0] KJ = 8'h1A;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic        internal_reset = 1'b0;
  logic        screen = 1'b1;
  logic [9:0]  py [2];
  logic        og [2];
  logic        jp [2];
  logic [15:0] jc [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  player_jump_ctrl dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .internal_reset(internal_reset), .screen(screen),
    .player_y(py[0]), .on_ground(og[0]), .jumping(jp[0]), .jump_count(jc[0])
  );

  player_jump_ctrl #(.CEIL_Y(350)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .internal_reset(internal_reset), .screen(screen),
    .player_y(py[1]), .on_ground(og[1]), .jumping(jp[1]), .jump_count(jc[1])
  );

  // Frame-level model: position, velocity, airborne flag, lockout frames left.
  int m_y [2], m_v [2], m_lock [2], m_jc [2];
  bit m_air [2], m_buf [2];
  int ceil_y [2] = '{16, 350};

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_ground_all(input int lock);
    for (int i = 0; i < 2; i++) begin
      m_air[i] = 0; m_y[i] = 400; m_v[i] = 0; m_lock[i] = lock; m_buf[i] = 0;
    end
  endtask

  task automatic m_launch(input int i);
    m_air[i] = 1; m_v[i] = -12; m_y[i] = 388; m_buf[i] = 0;
    if (m_jc[i] < 65535) m_jc[i]++;
  endtask

  task automatic m_tick(input int i, input bit key);
    if (m_lock[i] > 0) begin
      m_lock[i]--;
    end else if (!m_air[i]) begin
      if (key) m_launch(i);
    end else if (m_v[i] < 0) begin
      m_v[i] = m_v[i] + 1;
      m_y[i] = m_y[i] + m_v[i];
      if (m_y[i] < ceil_y[i]) begin m_y[i] = ceil_y[i]; m_v[i] = 0; end
    end else begin
      m_v[i] = (m_v[i] + 1 > 15) ? 15 : m_v[i] + 1;
      m_y[i] = m_y[i] + m_v[i];
`ifdef JUMP_BUFFER_EN
      if (key && m_y[i] >= 355) m_buf[i] = 1;
`endif
      if (m_y[i] >= 400) begin
        if (m_buf[i]) m_launch(i);
        else begin m_air[i] = 0; m_y[i] = 400; m_v[i] = 0; end
      end
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("y%0d", i), int'(py[i]), m_y[i]);
        check($sformatf("on_ground%0d", i), int'(og[i]), int'(!m_air[i]));
        check($sformatf("jumping%0d", i), int'(jp[i]), int'(m_air[i]));
        check($sformatf("jump_count%0d", i), int'(jc[i]), m_jc[i]);
      end
    end
  end

  task automatic do_frame(input logic [7:0] k, input bit scr, input bit irst);
    chk_en = 0;
    @(negedge Clk);
    keycode = k;
    screen  = scr;
    if (irst) begin
      internal_reset = 1'b1;
      @(negedge Clk);
      internal_reset = 1'b0;
      m_ground_all(30);
      check("irst_y", int'(py[0]), 400);
      check("irst_on_ground", int'(og[0]), 1);
    end
    if (!scr) m_ground_all(0);
    #($urandom_range(1, 9));
    frame_clk = 1'b1;
    if (scr) for (int i = 0; i < 2; i++) m_tick(i, k == KJ);
    repeat (5) @(posedge Clk);
    #2 frame_clk = 1'b0;
    @(negedge Clk);
    chk_en = 1;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    m_ground_all(0);
    m_jc = '{0, 0};
    #23;
    check("rst_y", int'(py[0]), 400);
    check("rst_on_ground", int'(og[0]), 1);
    check("rst_jumping", int'(jp[0]), 0);
    check("rst_jump_count", int'(jc[0]), 0);
    Reset_n = 1'b1;

    // single jump, key held for one tick
    do_frame(KJ, 1, 0);
    check("tick1_y", int'(py[0]), 388);
    check("tick1_jc", int'(jc[0]), 1);
    for (int t = 2; t <= 12; t++) begin
      do_frame(8'h00, 1, 0);
      if (t == 5) check("ceil350_tick5_y", int'(py[1]), 350);
    end
    check("tick12_y", int'(py[0]), 322);
    do_frame(8'h00, 1, 0);
    check("apex_y", int'(py[0]), 322);
    check("apex_jumping", int'(jp[0]), 1);
    for (int t = 14; t <= 25; t++) do_frame(8'h00, 1, 0);
    check("land_y", int'(py[0]), 400);
    check("land_on_ground", int'(og[0]), 1);
    check("land_jc", int'(jc[0]), 1);

    // key held: jumps on ticks 1 and 26, both landed by tick 50
    for (int t = 1; t <= 50; t++) do_frame(KJ, 1, 0);
    check("held_jc", int'(jc[0]), 3);
    check("held_y", int'(py[0]), 400);

    // internal_reset on tick 8 of a jump, key held through lockout
    do_frame(KJ, 1, 0);
    for (int t = 2; t <= 7; t++) do_frame(8'h00, 1, 0);
    do_frame(KJ, 1, 1);
    for (int t = 2; t <= 30; t++) do_frame(KJ, 1, 0);
    check("lockout_jc", int'(jc[0]), 4);
    check("lockout_y", int'(py[0]), 400);
    do_frame(KJ, 1, 0);
    check("post_lockout_jc", int'(jc[0]), 5);
    check("post_lockout_y", int'(py[0]), 388);
    for (int t = 2; t <= 25; t++) do_frame(8'h00, 1, 0);

    // menu screen ignores the key
    for (int t = 0; t < 10; t++) do_frame(KJ, 0, 0);
    check("menu_y", int'(py[0]), 400);
    check("menu_jc", int'(jc[0]), 5);

    // randomized play
    for (int t = 0; t < 400; t++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 1) != 0) ? KJ : 8'($urandom_range(0, 255));
      do_frame(k, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0);
    end

    // async reset mid-jump
    do_frame(KJ, 1, 0);
    do_frame(8'h00, 1, 0);
    do_frame(8'h00, 1, 0);
    chk_en = 0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midjump_rst_y", int'(py[0]), 400);
    check("midjump_rst_on_ground", int'(og[0]), 1);
    check("midjump_rst_jumping", int'(jp[0]), 0);
    check("midjump_rst_jc", int'(jc[0]), 0);
    m_ground_all(0);
    m_jc = '{0, 0};
    @(negedge Clk);
    Reset_n = 1'b1;
    do_frame(KJ, 1, 0);
    check("after_rst_jc", int'(jc[0]), 1);
    for (int t = 0; t < 5; t++) do_frame(8'h00, 1, 0);

    chk_en = 0;
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
